// File: rtl/pixie_dma_responder.sv
// DMA-out responder for the CDP1861 pixie video path: fetches display bytes at R0,
// hands each to the video front end with a one-cycle strobe and post-increments R0.
module pixie_dma_responder #(
   parameter int ADDR_W    = 16,
   parameter int BURST_LEN = 8,
   parameter int RAM_LAT   = 1
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dma_out_req,
   input  logic              cpu_mem_busy,
   input  logic              r0_load,
   input  logic [ADDR_W-1:0] r0_din,
   output logic [ADDR_W-1:0] r0_q,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_a,
   input  logic [7:0]        mem_q,
   output logic [7:0]        dma_data,
   output logic              dma_valid,
   output logic [1:0]        sc,
   output logic              burst_done,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_READ    = 3'd2,
      S_WAIT    = 3'd3,
      S_DELIVER = 3'd4
   } state_t;

   localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [1:0]        WAIT_INIT = 2'(RAM_LAT - 1);
   localparam logic [1:0]        SC_DMA    = 2'b10;
   localparam logic [1:0]        SC_EXEC   = 2'b01;

   state_t            state;
   logic [ADDR_W-1:0] addr_lat;
   logic [BEAT_W-1:0] beat;
   logic [1:0]        wait_cnt;

   assign state_dbg = state;

   // dma_valid is a one-cycle strobe with no back-pressure: the video side must take
   // dma_data in the cycle dma_valid=1. mem_rd likewise has no ready; RAM answers RAM_LAT later.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         r0_q       <= '0;
         addr_lat   <= '0;
         dma_data   <= '0;
         beat       <= '0;
         wait_cnt   <= '0;
         mem_rd     <= 1'b0;
         mem_a      <= '0;
         dma_valid  <= 1'b0;
         burst_done <= 1'b0;
         sc         <= SC_EXEC;
      end else begin
         mem_rd     <= 1'b0;
         dma_valid  <= 1'b0;
         burst_done <= 1'b0;
         if (r0_load) begin
            r0_q <= r0_din;
         end
         case (state)
            S_IDLE: begin
               if (dma_out_req) begin
                  state <= S_ARB;
               end else begin
                  beat <= '0;
               end
            end
            S_ARB: begin
               if (!cpu_mem_busy) begin
                  state    <= S_READ;
                  addr_lat <= r0_load ? r0_din : r0_q;
                  mem_a    <= r0_load ? r0_din : r0_q;
                  mem_rd   <= 1'b1;
                  sc       <= SC_DMA;
               end
            end
            S_READ: begin
               state    <= S_WAIT;
               wait_cnt <= WAIT_INIT;
            end
            S_WAIT: begin
               if (wait_cnt == 2'd0) begin
                  state      <= S_DELIVER;
                  dma_data   <= mem_q;
                  dma_valid  <= 1'b1;
                  burst_done <= (beat == BEAT_LAST);
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            S_DELIVER: begin
               // A CPU load in this cycle takes precedence over the post-increment.
               if (!r0_load) begin
                  r0_q <= addr_lat + ADDR_ONE;
               end
               beat  <= (beat == BEAT_LAST) ? '0 : beat + BEAT_ONE;
               sc    <= SC_EXEC;
               state <= dma_out_req ? S_ARB : S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               sc    <= SC_EXEC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixie_dma_responder.sv
// Bench for pixie_dma_responder: two instances (RAM latency 1 and 3) share stimulus;
// each burst is checked against pointer/timing rules computed directly from the byte index.
module tb_pixie_dma_responder;

   localparam int BURST = 8;

   logic        clk = 1'b0;
   logic        rst_n, req, busy, r0_load;
   logic [15:0] r0_din;

   logic [15:0] a_r0, a_a, b_r0, b_a;
   logic        a_rd, a_val, a_done, b_rd, b_val, b_done;
   logic [7:0]  a_data, b_data, a_q, b_q;
   logic [1:0]  a_sc, b_sc;
   logic [2:0]  a_st, b_st;

   logic [7:0]  ram [0:65535];
   logic [7:0]  p0, p1, p2;

   bit          sel;
   logic [15:0] o_r0, o_a;
   logic        o_rd, o_val, o_done;
   logic [7:0]  o_data;
   logic [1:0]  o_sc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pixie_dma_responder #(.ADDR_W(16), .BURST_LEN(BURST), .RAM_LAT(1)) dut_a (
      .clk_sys(clk), .reset_n(rst_n), .dma_out_req(req), .cpu_mem_busy(busy),
      .r0_load(r0_load), .r0_din(r0_din), .r0_q(a_r0), .mem_rd(a_rd), .mem_a(a_a),
      .mem_q(a_q), .dma_data(a_data), .dma_valid(a_val), .sc(a_sc),
      .burst_done(a_done), .state_dbg(a_st));

   pixie_dma_responder #(.ADDR_W(16), .BURST_LEN(BURST), .RAM_LAT(3)) dut_b (
      .clk_sys(clk), .reset_n(rst_n), .dma_out_req(req), .cpu_mem_busy(busy),
      .r0_load(r0_load), .r0_din(r0_din), .r0_q(b_r0), .mem_rd(b_rd), .mem_a(b_a),
      .mem_q(b_q), .dma_data(b_data), .dma_valid(b_val), .sc(b_sc),
      .burst_done(b_done), .state_dbg(b_st));

   // RAM models: data for an address appears 1 (a) or 3 (b) cycles after it is presented.
   always @(posedge clk) begin
      a_q <= ram[a_a];
      p0  <= ram[b_a];
      p1  <= p0;
      p2  <= p1;
   end
   assign b_q = p2;

   assign o_r0   = sel ? b_r0   : a_r0;
   assign o_a    = sel ? b_a    : a_a;
   assign o_rd   = sel ? b_rd   : a_rd;
   assign o_val  = sel ? b_val  : a_val;
   assign o_done = sel ? b_done : a_done;
   assign o_data = sel ? b_data : a_data;
   assign o_sc   = sel ? b_sc   : a_sc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset(input string who);
      check({who, " r0_q"},       32'(o_r0),   32'h0);
      check({who, " mem_rd"},     32'(o_rd),   32'h0);
      check({who, " mem_a"},      32'(o_a),    32'h0);
      check({who, " dma_data"},   32'(o_data), 32'h0);
      check({who, " dma_valid"},  32'(o_val),  32'h0);
      check({who, " burst_done"}, 32'(o_done), 32'h0);
      check({who, " sc"},         32'(o_sc),   32'h1);
   endtask

   // One burst of n bytes starting at R0=start. Timing: first read two cycles after the
   // request (or one cycle after busy clears), then a byte every 3+lat cycles.
   task automatic run(input bit s, input logic [15:0] start, input int n, input int busy_len,
                      input int load_idx, input logic [15:0] load_val, input bit drop_early);
      int          lat        = s ? 3 : 1;
      int          per        = 3 + lat;
      int          rd0        = ((busy_len > 1) ? busy_len : 1) + 1;
      int          last_valid = rd0 + (n - 1) * per + 1 + lat;
      int          k_val      = 0;
      int          off;
      bit          in_rd, in_val, in_svc, exp_done;
      logic [15:0] ptr        = start;
      sel     = s;
      r0_load = 1'b1;
      r0_din  = start;
      req     = 1'b0;
      busy    = 1'b0;
      step();
      r0_load = 1'b0;
      req     = 1'b1;
      busy    = (busy_len > 0);
      for (int c = 1; c <= last_valid + 4; c++) begin
         step();
         off    = c - rd0;
         in_rd  = (off >= 0) && (off / per < n) && (off % per == 0);
         in_val = (off >= 0) && (off / per < n) && (off % per == 1 + lat);
         in_svc = (off >= 0) && (off / per < n) && (off % per <= 1 + lat);
         exp_done = in_val && (k_val % BURST == BURST - 1);
         check("r0_q", 32'(o_r0), 32'(ptr));
         check("mem_rd", 32'(o_rd), 32'(in_rd));
         check("dma_valid", 32'(o_val), 32'(in_val));
         check("burst_done", 32'(o_done), 32'(exp_done));
         check("sc", 32'(o_sc), in_svc ? 32'h2 : 32'h1);
         if (in_rd) check("mem_a", 32'(o_a), 32'(ptr));
         r0_load = 1'b0;
         if (in_val) begin
            check("dma_data", 32'(o_data), 32'(ram[ptr]));
            if (k_val == load_idx) begin
               r0_load = 1'b1;
               r0_din  = load_val;
               ptr     = load_val;
            end else begin
               ptr = ptr + 16'd1;
            end
            if (k_val == n - 1) req = 1'b0;
            k_val++;
         end
         if (drop_early && in_rd) req = 1'b0;
         busy = (c < busy_len);
      end
      req     = 1'b0;
      r0_load = 1'b0;
      busy    = 1'b0;
      check("final r0_q", 32'(o_r0), 32'(ptr));
      repeat (8) step();
   endtask

   initial begin
      int          n, bl, li;
      logic [15:0] st, lv;
      rst_n   = 1'b0;
      req     = 1'b0;
      busy    = 1'b0;
      r0_load = 1'b0;
      r0_din  = '0;
      sel     = 1'b0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) ram[16'h0900 + i] = 8'(i);
      repeat (3) step();
      sel = 1'b0;
      check_reset("a reset");
      sel = 1'b1;
      check_reset("b reset");
      rst_n = 1'b1;
      repeat (2) step();

      run(1'b0, 16'h0900, 8, 0, -1, 16'h0, 1'b0);
      run(1'b0, 16'h0910, 3, 6, -1, 16'h0, 1'b0);
      run(1'b0, 16'hFFFF, 1, 0, -1, 16'h0, 1'b0);
      run(1'b0, 16'h0900, 8, 0, 5, 16'h0A00, 1'b0);

      // Reset while the byte is in WAIT: it must be dropped silently.
      sel     = 1'b0;
      r0_load = 1'b1;
      r0_din  = 16'h1234;
      step();
      r0_load = 1'b0;
      req     = 1'b1;
      repeat (3) step();
      check("wait sc", 32'(o_sc), 32'h2);
      check("wait mem_rd", 32'(o_rd), 32'h0);
      rst_n = 1'b0;
      req   = 1'b0;
      step();
      check_reset("mid reset");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("post reset dma_valid", 32'(o_val), 32'h0);
         check("post reset r0_q", 32'(o_r0), 32'h0);
      end

      run(1'b1, 16'h0300, 1, 0, -1, 16'h0, 1'b1);
      run(1'b1, 16'h0300, 8, 0, -1, 16'h0, 1'b0);

      repeat (8) begin
         n  = int'($urandom_range(1, 12));
         bl = int'($urandom_range(0, 4));
         li = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
         st = 16'($urandom);
         lv = 16'($urandom);
         run(1'($urandom_range(0, 1)), st, n, bl, li, lv, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
